// File: rtl/drap_ifetch_pc_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/ack channel, the
// decode-side valid/ready channel and the redirect inputs.
interface drap_ifetch_pc_unit_if #(
   parameter int B      = 32,
   parameter int BOFF_W = 16,
   parameter int JIDX_W = 26
);
   // instruction memory channel
   logic              imem_req;
   logic [B-1:0]      imem_addr;
   logic              imem_ack;
   logic [B-1:0]      imem_rdata;

   // decode channel
   logic [B-1:0]      instr;
   logic [B-1:0]      instr_pc;
   logic              instr_valid;
   logic              instr_ready;

   // redirect inputs
   logic              br_taken;
   logic [B-1:0]      br_pc;
   logic [BOFF_W-1:0] br_off;
   logic              jmp;
   logic [JIDX_W-1:0] jmp_idx;
   logic              jr;
   logic [B-1:0]      jr_target;
   logic              align_err;

   // fetch unit side
   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, align_err,
      input  imem_ack, imem_rdata, instr_ready,
      input  br_taken, br_pc, br_off, jmp, jmp_idx, jr, jr_target
   );

   // memory / decode / branch-unit side
   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, align_err,
      output imem_ack, imem_rdata, instr_ready,
      output br_taken, br_pc, br_off, jmp, jmp_idx, jr, jr_target
   );
endinterface

// File: rtl/drap_ifetch_pc_unit.sv
// Instruction-fetch PC unit. Holds the PC, issues one outstanding fetch at a
// time to instruction memory, buffers one fetched word for decode and
// redirects on jr / jmp / taken branch (priority in that order). A redirect
// that arrives while a fetch is in flight marks that fetch as squashed so its
// data is dropped when the ack finally comes back.
module drap_ifetch_pc_unit #(
   parameter int           B        = 32,
   parameter logic [B-1:0] RESET_PC = '0,
   parameter int           INC      = 4,
   parameter int           BOFF_W   = 16,
   parameter int           JIDX_W   = 26
) (
   input  logic                  clk,
   input  logic                  rst_n,
   drap_ifetch_pc_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [B-1:0] INC_B = B'(INC);
   // low bits replaced by the jump index (index plus the two byte bits)
   localparam logic [B-1:0] JMASK = {B{1'b1}} >> (B - JIDX_W - 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [B-1:0]        r_pc;
   logic [B-1:0]        w_pc_nxt;
   logic [B-1:0]        r_pc_req;
   logic [B-1:0]        w_pc_req_nxt;
   logic [B-1:0]        r_instr;
   logic [B-1:0]        w_instr_nxt;
   logic [B-1:0]        r_instr_pc;
   logic [B-1:0]        w_instr_pc_nxt;
   logic                r_instr_valid;
   logic                w_instr_valid_nxt;
   logic                r_squash;
   logic                w_squash_nxt;
   logic                r_align_err;
   logic                w_align_err_nxt;

   logic                w_redir;
   logic [B-1:0]        w_base;
   logic signed [BOFF_W-1:0] w_boff;
   logic signed [B-1:0] w_boff_ext;
   logic [B-1:0]        w_jr_tgt;
   logic [B-1:0]        w_jmp_tgt;
   logic [B-1:0]        w_br_tgt;
   logic [B-1:0]        w_target;

   // Redirect target arithmetic; every add is B bits and wraps.
   assign w_redir    = bus.jr | bus.jmp | bus.br_taken;
   assign w_base     = bus.br_pc + INC_B;
   assign w_boff     = bus.br_off;
   assign w_boff_ext = B'(w_boff);
   assign w_jr_tgt   = {bus.jr_target[B-1:2], 2'b00};
   assign w_jmp_tgt  = (w_base & ~JMASK) | B'({bus.jmp_idx, 2'b00});
   assign w_br_tgt   = $unsigned($signed(w_base) + (w_boff_ext <<< 2));

   // Redirect priority: jr over jmp over taken branch.
   always_comb begin
      w_target = w_br_tgt;
      if (bus.jr) begin
         w_target = w_jr_tgt;
      end else if (bus.jmp) begin
         w_target = w_jmp_tgt;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_pc_req      <= RESET_PC;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_squash      <= 1'b0;
         r_align_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_pc_req      <= w_pc_req_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_squash      <= w_squash_nxt;
         r_align_err   <= w_align_err_nxt;
      end
   end

   // Next-state logic for the fetch sequencer and the single-entry buffer.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_pc_req_nxt      = r_pc_req;
      w_instr_nxt       = r_instr;
      w_instr_pc_nxt    = r_instr_pc;
      w_instr_valid_nxt = r_instr_valid;
      w_squash_nxt      = r_squash;
      // a misaligned jr target is truncated; flag it for one cycle
      w_align_err_nxt   = bus.jr & (|bus.jr_target[1:0]);

      case (r_state)
         S_IDLE: begin
            // one quiet cycle after reset; a redirect here replaces RESET_PC
            w_state_nxt = S_REQ;
            if (w_redir) begin
               w_pc_nxt          = w_target;
               w_pc_req_nxt      = w_target;
               w_instr_valid_nxt = 1'b0;
            end
         end

         S_REQ: begin
            if (bus.imem_ack) begin
               if (w_redir || r_squash) begin
                  // stale data: drop it and immediately refetch from the new pc
                  w_squash_nxt = 1'b0;
                  if (w_redir) begin
                     w_pc_nxt     = w_target;
                     w_pc_req_nxt = w_target;
                  end else begin
                     w_pc_req_nxt = r_pc;
                  end
               end else begin
                  w_instr_nxt       = bus.imem_rdata;
                  w_instr_pc_nxt    = r_pc_req;
                  w_instr_valid_nxt = 1'b1;
                  w_pc_nxt          = r_pc_req + INC_B;
                  w_state_nxt       = S_HOLD;
               end
            end else if (w_redir) begin
               // request address must stay stable; remember to drop its data
               w_pc_nxt     = w_target;
               w_squash_nxt = 1'b1;
            end
         end

         S_HOLD: begin
            if (w_redir) begin
               // redirect flushes the buffer even if decode accepts this cycle
               w_pc_nxt          = w_target;
               w_pc_req_nxt      = w_target;
               w_instr_valid_nxt = 1'b0;
               w_state_nxt       = S_REQ;
            end else if (bus.instr_ready) begin
               w_instr_valid_nxt = 1'b0;
               w_pc_req_nxt      = r_pc;
               w_state_nxt       = S_REQ;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.imem_req    = (r_state == S_REQ);
   assign bus.imem_addr   = r_pc_req;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_valid = r_instr_valid;
   assign bus.align_err   = r_align_err;

endmodule

// File: doc/drap_ifetch_pc_unit.md
Name: drap_ifetch_pc_unit

Overview:
Parametrised instruction-fetch PC unit for the MIPS datapath. It succeeds the plain IFETCH adder. It holds the PC register and generates sequential addresses (PC+INC). It computes branch, jump and jump-register targets and runs a single-outstanding request/ack handshake to instruction memory. It sits between imem and the decode stage, delivering {instr, instr_pc} with a valid/ready handshake and squashing fetches on redirect.

Parameters:
B, 32, data/address width in bits
RESET_PC, 0, PC value loaded on reset
INC, 4, sequential PC increment in bytes
BOFF_W, 16, branch offset width (signed word offset)
JIDX_W, 26, jump index width; requires B >= JIDX_W+2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, level; held until imem_ack
imem_addr  out  B  fetch address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  B  fetched instruction word
instr  out  B  instruction to decode
instr_pc  out  B  address of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts when instr_valid & instr_ready
br_taken  in  1  branch redirect pulse
br_pc  in  B  PC of the redirecting instruction (used by br and jmp)
br_off  in  BOFF_W  signed branch word offset
jmp  in  1  jump redirect pulse
jmp_idx  in  JIDX_W  jump word index
jr  in  1  jump-register redirect pulse
jr_target  in  B  jump-register target
align_err  out  1  one-cycle pulse when jr_target[1:0] != 0

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, align_err=0, squash=0, state=IDLE.
- FSM states:
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc_req.
  - HOLD: output buffer full, waiting for instr_ready.
- REQ with imem_ack and not squash:
  - instr<=imem_rdata, instr_pc<=pc_req, instr_valid<=1, pc<=pc_req+INC.
  - Go to HOLD. Output buffer is a single-entry buffer.
- HOLD with instr_ready=1: instr_valid<=0; pc_req<=pc; go to REQ next cycle. Latency is 1 fetch per 2 cycles minimum with a 1-cycle ack.
- Redirect target, priority jr > jmp > br_taken, with base = br_pc+INC:
  - jr: {jr_target[B-1:2],2'b00}; align_err pulses 1 cycle if jr_target[1:0]!=0.
  - jmp: {base[B-1:JIDX_W+2], jmp_idx, 2'b00}.
  - br: base + (sign_extend(br_off) << 2), modulo 2^B.
- Redirect in IDLE or HOLD:
  - pc<=target; instr_valid<=0 (flush).
  - Go to REQ with pc_req<=target.
  - From IDLE, the target overrides RESET_PC.
- Redirect in REQ, request outstanding:
  - imem_addr is not changed; pc<=target; squash<=1.
  - On imem_ack with squash=1: discard imem_rdata, clear squash, pc_req<=pc, stay in REQ (new request next cycle, imem_req stays 1).
- Redirect in the same cycle as imem_ack: the acked data is discarded, and the redirect target is fetched next.
- Redirect in the same cycle as instr_ready in HOLD: the accepted instruction is consumed and the redirect wins for the next pc.
- Arithmetic: all adds are B-bit and wrap silently (0xFFFFFFFC+4=0x00000000). There is no overflow flag.
- Reset asserted mid-request: all state is cleared asynchronously. A late imem_ack after reset is ignored while in IDLE.
- Spurious imem_ack outside REQ is ignored.

Test Plan:
- Reset release, RESET_PC=0x00400000, ack 1 cycle after each req, ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_pc matches; instr_valid never high without a prior ack.
- Backpressure: ready=0 for 5 cycles with instr_valid=1 -> instr/instr_pc stable, imem_req=0. Release -> next fetch at instr_pc+4.
- br_taken with br_pc=0x100, br_off=0xFFFE -> next imem_addr=0x000000FC; held instr flushed (instr_valid=0 next cycle).
- jr=1 and jmp=1 same cycle, jr_target=0x2003, jmp_idx=0x10 -> fetch 0x2000; align_err pulses 1 cycle; jmp ignored.
- Redirect in REQ, ack delayed 3 cycles, jmp with br_pc=0x30000000, jmp_idx=0x40 -> imem_addr unchanged until ack; acked data never appears on instr; next imem_addr=0x30000100.
- pc at 0xFFFFFFFC, ack, ready -> next imem_addr=0x00000000. Assert rst_n=0 mid-REQ -> all outputs return to reset values immediately.
